// File: rtl/dram_uart_tx.sv
// Result uploader: walks a byte-wide DRAM region and sends each byte to the PC
// as an 8N1 UART frame, then flags completion to main_control.
module dram_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [15:0] START_ADDR   = 16'd0,
    parameter logic [15:0] END_ADDR     = 16'd8,
    parameter int          READ_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_transmit,
    input  logic [7:0]  mem_q,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    output logic        data_to_pc,
    output logic        busy,
    output logic        end_transmitting
);

    localparam int                BAUD_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]        FETCH_LAST = 2'(READ_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t             state;
    logic               start_prev;
    logic               start_edge;
    logic               baud_done;
    logic [7:0]         shift_reg;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_idx;
    logic [1:0]         fetch_cnt;

    assign start_edge = start_transmit & ~start_prev;
    assign baud_done  = (baud_cnt == BAUD_LAST);

    // The byte is latched once at the end of FETCH, so DRAM activity during
    // the frame cannot disturb what is already on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            start_prev       <= 1'b0;
            mem_addr         <= START_ADDR;
            mem_req          <= 1'b0;
            data_to_pc       <= 1'b1;
            busy             <= 1'b0;
            end_transmitting <= 1'b0;
            shift_reg        <= 8'd0;
            baud_cnt         <= '0;
            bit_idx          <= 3'd0;
            fetch_cnt        <= 2'd0;
        end else begin
            start_prev <= start_transmit;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        state            <= S_FETCH;
                        mem_addr         <= START_ADDR;
                        mem_req          <= 1'b1;
                        busy             <= 1'b1;
                        end_transmitting <= 1'b0;
                        data_to_pc       <= 1'b1;
                        fetch_cnt        <= 2'd0;
                        baud_cnt         <= '0;
                        bit_idx          <= 3'd0;
                    end
                end
                S_FETCH: begin
                    if (fetch_cnt == FETCH_LAST) begin
                        shift_reg  <= mem_q;
                        fetch_cnt  <= 2'd0;
                        baud_cnt   <= '0;
                        data_to_pc <= 1'b0;
                        state      <= S_START;
                    end else begin
                        fetch_cnt <= fetch_cnt + 2'd1;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt   <= '0;
                        bit_idx    <= 3'd0;
                        data_to_pc <= shift_reg[0];
                        state      <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            data_to_pc <= 1'b1;
                            state      <= S_STOP;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            data_to_pc <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Compare before incrementing so END_ADDR of 16'hFFFF never wraps.
                        if (mem_addr == END_ADDR) begin
                            state            <= S_DONE;
                            busy             <= 1'b0;
                            mem_req          <= 1'b0;
                            end_transmitting <= 1'b1;
                        end else begin
                            mem_addr  <= mem_addr + 16'd1;
                            fetch_cnt <= 2'd0;
                            state     <= S_FETCH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_uart_tx.sv
// Scoreboard bench for dram_uart_tx: three instances (4-byte upload, single byte,
// two-cycle DRAM latency) with UART line decoders popping expected bytes.
module tb_dram_uart_tx;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic [15:0] addr_a, addr_b, addr_c;
    logic [7:0]  q_a, q_b, q_c, q_c1;
    logic        req_a, req_b, req_c;
    logic        line_a, line_b, line_c;
    logic        busy_a, busy_b, busy_c;
    logic        end_a, end_b, end_c;
    logic [2:0]  rst_v, line_v, busy_v, end_v, req_v;
    logic [7:0]  mem_a [16];
    logic [7:0]  mem_b [16];
    logic [7:0]  mem_c [16];
    logic [7:0]  frame_bytes [4];
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];
    logic [7:0]  exp_q2 [$];
    int          rst_cnt0 = 0, rst_cnt1 = 0, rst_cnt2 = 0;
    int          checks = 0;
    int          errors = 0;

    assign rst_v  = {rst_c, rst_b, rst_a};
    assign line_v = {line_c, line_b, line_a};
    assign busy_v = {busy_c, busy_b, busy_a};
    assign end_v  = {end_c, end_b, end_a};
    assign req_v  = {req_c, req_b, req_a};

    always #5 clk = ~clk;

    dram_uart_tx #(.CLKS_PER_BIT(4), .START_ADDR(16'd0), .END_ADDR(16'd3), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .start_transmit(start_v[0]), .mem_q(q_a),
        .mem_addr(addr_a), .mem_req(req_a), .data_to_pc(line_a),
        .busy(busy_a), .end_transmitting(end_a));

    dram_uart_tx #(.CLKS_PER_BIT(4), .START_ADDR(16'd5), .END_ADDR(16'd5), .READ_LAT(1)) dut_b (
        .clk(clk), .rst(rst_b), .start_transmit(start_v[1]), .mem_q(q_b),
        .mem_addr(addr_b), .mem_req(req_b), .data_to_pc(line_b),
        .busy(busy_b), .end_transmitting(end_b));

    dram_uart_tx #(.CLKS_PER_BIT(4), .START_ADDR(16'd0), .END_ADDR(16'd3), .READ_LAT(2)) dut_c (
        .clk(clk), .rst(rst_c), .start_transmit(start_v[2]), .mem_q(q_c),
        .mem_addr(addr_c), .mem_req(req_c), .data_to_pc(line_c),
        .busy(busy_c), .end_transmitting(end_c));

    // DRAM models: one registered read stage, or two for the slow instance.
    always @(posedge clk) begin
        q_a  <= mem_a[addr_a[3:0]];
        q_b  <= mem_b[addr_b[3:0]];
        q_c1 <= mem_c[addr_c[3:0]];
        q_c  <= q_c1;
    end

    always @(posedge rst_a) rst_cnt0++;
    always @(posedge rst_b) rst_cnt1++;
    always @(posedge rst_c) rst_cnt2++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] getAddr(input int k);
        case (k)
            0:       return addr_a;
            1:       return addr_b;
            default: return addr_c;
        endcase
    endfunction

    function automatic int getRstCnt(input int k);
        case (k)
            0:       return rst_cnt0;
            1:       return rst_cnt1;
            default: return rst_cnt2;
        endcase
    endfunction

    function automatic int qSize(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic pushExp(input int k, input logic [7:0] b);
        case (k)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
    endtask

    task automatic popExp(input int k, output logic [7:0] b);
        case (k)
            0:       b = exp_q0.pop_front();
            1:       b = exp_q1.pop_front();
            default: b = exp_q2.pop_front();
        endcase
    endtask

    // Decodes frames on one instance's line; a reset during the frame discards it.
    task automatic monitorLine(input int k);
        logic [7:0] got;
        logic [7:0] want;
        logic       start_bit;
        logic       stop_bit;
        int         rc;
        forever begin
            @(negedge clk);
            if (rst_v[k] == 1'b0 && line_v[k] === 1'b0) begin
                rc = getRstCnt(k);
                repeat (2) @(negedge clk);
                start_bit = line_v[k];
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    got[i] = line_v[k];
                end
                repeat (4) @(negedge clk);
                stop_bit = line_v[k];
                if (rc == getRstCnt(k)) begin
                    checkOutput($sformatf("start_bit_dut%0d", k), {31'd0, start_bit}, 32'd0);
                    checkOutput($sformatf("stop_bit_dut%0d", k), {31'd0, stop_bit}, 32'd1);
                    checks++;
                    if (qSize(k) == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_frame_dut%0d: got byte %0h, expected no frame", k, got);
                    end else begin
                        popExp(k, want);
                        checkOutput($sformatf("byte_dut%0d", k), {24'd0, got}, {24'd0, want});
                    end
                end
            end
        end
    endtask

    initial monitorLine(0);
    initial monitorLine(1);
    initial monitorLine(2);

    // Queues the expected bytes, raises start and times the upload to end_transmitting.
    task automatic applyStimulus(input int k, input bit hold, input int pulse_at,
                                 input bit corrupt, input int exp_cycles);
        int         cycles;
        logic       prev_busy;
        logic [15:0] first_addr;
        logic [15:0] last_addr;
        first_addr = (k == 1) ? 16'd5 : 16'd0;
        last_addr  = (k == 1) ? 16'd5 : 16'd3;
        if (k == 1) pushExp(k, 8'h81);
        else for (int i = 0; i < 4; i++) pushExp(k, frame_bytes[i]);
        @(posedge clk);
        #1 start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput($sformatf("busy_after_edge_dut%0d", k), {31'd0, busy_v[k]}, 32'd1);
        checkOutput($sformatf("req_after_edge_dut%0d", k), {31'd0, req_v[k]}, 32'd1);
        checkOutput($sformatf("end_after_edge_dut%0d", k), {31'd0, end_v[k]}, 32'd0);
        checkOutput($sformatf("addr_after_edge_dut%0d", k), {16'd0, getAddr(k)}, {16'd0, first_addr});
        if (!hold) start_v[k] = 1'b0;
        cycles    = 0;
        prev_busy = busy_v[k];
        while (end_v[k] !== 1'b1 && cycles < 1000) begin
            prev_busy = busy_v[k];
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == pulse_at) start_v[k] = 1'b1;
            else if (cycles == pulse_at + 1 && !hold) start_v[k] = 1'b0;
            if (corrupt && cycles == 10) mem_a[0] = 8'h11;
            if (corrupt && cycles == 30) mem_a[0] = frame_bytes[0];
        end
        checkOutput($sformatf("done_cycles_dut%0d", k), cycles, exp_cycles);
        checkOutput($sformatf("busy_before_done_dut%0d", k), {31'd0, prev_busy}, 32'd1);
        checkOutput($sformatf("busy_at_done_dut%0d", k), {31'd0, busy_v[k]}, 32'd0);
        checkOutput($sformatf("req_at_done_dut%0d", k), {31'd0, req_v[k]}, 32'd0);
        checkOutput($sformatf("line_at_done_dut%0d", k), {31'd0, line_v[k]}, 32'd1);
        checkOutput($sformatf("addr_at_done_dut%0d", k), {16'd0, getAddr(k)}, {16'd0, last_addr});
    endtask

    initial begin
        frame_bytes[0] = 8'hA5;
        frame_bytes[1] = 8'h3C;
        frame_bytes[2] = 8'h00;
        frame_bytes[3] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
            mem_c[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = frame_bytes[i];
            mem_c[i] = frame_bytes[i];
        end
        mem_b[5] = 8'h81;
        mem_b[4] = 8'h7E;
        mem_b[6] = 8'h7E;

        #1 rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_line_dut%0d", k), {31'd0, line_v[k]}, 32'd1);
            checkOutput($sformatf("reset_busy_dut%0d", k), {31'd0, busy_v[k]}, 32'd0);
            checkOutput($sformatf("reset_end_dut%0d", k), {31'd0, end_v[k]}, 32'd0);
            checkOutput($sformatf("reset_req_dut%0d", k), {31'd0, req_v[k]}, 32'd0);
            checkOutput($sformatf("reset_addr_dut%0d", k), {16'd0, getAddr(k)},
                        (k == 1) ? 32'd5 : 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] four-byte upload");
        applyStimulus(0, 1'b0, -1, 1'b0, 168);
        repeat (20) @(posedge clk);

        $display("[TB] single-byte upload");
        applyStimulus(1, 1'b0, -1, 1'b0, 42);
        repeat (20) @(posedge clk);

        $display("[TB] restart with mid-frame start pulse and DRAM changing under the frame");
        applyStimulus(0, 1'b0, 20, 1'b1, 168);
        repeat (20) @(posedge clk);

        $display("[TB] start held high");
        applyStimulus(0, 1'b1, -1, 1'b0, 168);
        repeat (340) @(posedge clk);
        #1 start_v[0] = 1'b0;
        checkOutput("held_start_end_still_high", {31'd0, end_v[0]}, 32'd1);
        checkOutput("held_start_no_extra_frames", qSize(0), 0);
        repeat (20) @(posedge clk);

        $display("[TB] reset during second byte");
        for (int i = 0; i < 4; i++) pushExp(0, frame_bytes[i]);
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (54) @(posedge clk);
        #3 rst_a = 1'b1;
        #1;
        checkOutput("midreset_line", {31'd0, line_a}, 32'd1);
        checkOutput("midreset_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("midreset_req", {31'd0, req_a}, 32'd0);
        checkOutput("midreset_addr", {16'd0, addr_a}, 32'd0);
        checkOutput("midreset_first_byte_seen", exp_q0.size(), 3);
        exp_q0.delete();
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (60) @(posedge clk);
        applyStimulus(0, 1'b0, -1, 1'b0, 168);
        repeat (20) @(posedge clk);

        $display("[TB] two-cycle DRAM latency");
        applyStimulus(2, 1'b0, -1, 1'b0, 172);

        repeat (60) @(posedge clk);
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("queue_drained_dut%0d", k), qSize(k), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
